// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB broadcast path: register-index widths and the
// registered CDB record that the PRF, wakeup and ROB consumers all decode.
package rv32i_types;
  localparam int XLEN            = 32;
  localparam int NUM_FU          = 4;
  localparam int ARCH_REG_IDX    = 4;
  localparam int PHYS_REG_IDX    = 5;
  localparam int NUM_ROB_ENTRIES = 16;
  localparam int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       value;
    logic [ARCH_REG_IDX:0] rd;
    logic [PHYS_REG_IDX:0] pd;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic                  dest_we;
  } cdb_t;
endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin request search: first requester at or after ptr wins, and the
// pointer moves one past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               j;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    // Grants are suppressed during reset so pending requests are dropped.
    gnt   = (found && !rst) ? (N'(1) << gnt_idx) : '0;
    ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Collects FU completions and drives one registered CDB broadcast per cycle,
// choosing among requesters round-robin. No backpressure from the CDB side.
module cdb_arbiter #(
  parameter int XLEN   = rv32i_types::XLEN,
  parameter int NUM_FU = rv32i_types::NUM_FU,
  parameter int GI_W   = $clog2(NUM_FU)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUM_FU-1:0]                                    fu_valid,
  output logic [NUM_FU-1:0]                                    fu_ready,
  input  logic [NUM_FU-1:0][XLEN-1:0]                          fu_value,
  input  logic [NUM_FU-1:0][rv32i_types::ARCH_REG_IDX:0]       fu_rd,
  input  logic [NUM_FU-1:0][rv32i_types::PHYS_REG_IDX:0]       fu_pd,
  input  logic [NUM_FU-1:0][rv32i_types::ROB_IDX_W-1:0]        fu_rob_idx,
  input  logic [NUM_FU-1:0]                                    fu_dest_we,
  output logic                                                 cdb_valid,
  output logic [XLEN-1:0]                                      cdb_value,
  output logic [rv32i_types::ARCH_REG_IDX:0]                   cdb_rd,
  output logic [rv32i_types::PHYS_REG_IDX:0]                   cdb_pd,
  output logic [rv32i_types::ROB_IDX_W-1:0]                    cdb_rob_idx,
  output logic                                                 cdb_dest_we,
  output logic [GI_W-1:0]                                      grant_idx
);
  import rv32i_types::*;

  logic [NUM_FU-1:0] gnt;
  logic [GI_W-1:0]   gidx;
  logic              xfer;
  cdb_t              cdb_q, cdb_d;
  logic [GI_W-1:0]   gidx_q;

  rr_arbiter #(.N(NUM_FU), .IDX_W(GI_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (fu_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  assign fu_ready = gnt;
  assign xfer     = |gnt;

  // Fields only move on a transfer; consumers qualify them with valid.
  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = xfer;
    if (xfer) begin
      cdb_d.value   = fu_value[gidx];
      cdb_d.rd      = fu_rd[gidx];
      cdb_d.pd      = fu_pd[gidx];
      cdb_d.rob_idx = fu_rob_idx[gidx];
      cdb_d.dest_we = fu_dest_we[gidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q  <= '0;
      gidx_q <= '0;
    end else begin
      cdb_q <= cdb_d;
      if (xfer) gidx_q <= gidx;
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_value   = cdb_q.value;
  assign cdb_rd      = cdb_q.rd;
  assign cdb_pd      = cdb_q.pd;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_dest_we = cdb_q.dest_we;
  assign grant_idx   = gidx_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench: stimulus predicts grants and queues expected CDB records;
// a negedge monitor matches each broadcast against the queue by due cycle.
module tb_cdb_arbiter;
  localparam int NF = 4;

  typedef struct {
    int          due;
    logic [31:0] v;
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [3:0]  rob;
    logic        we;
    logic [1:0]  gi;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NF-1:0]         fu_valid, fu_ready, fu_dest_we;
  logic [NF-1:0][31:0]   fu_value;
  logic [NF-1:0][4:0]    fu_rd;
  logic [NF-1:0][5:0]    fu_pd;
  logic [NF-1:0][3:0]    fu_rob_idx;
  logic                  cdb_valid, cdb_dest_we;
  logic [31:0]           cdb_value;
  logic [4:0]            cdb_rd;
  logic [5:0]            cdb_pd;
  logic [3:0]            cdb_rob_idx;
  logic [1:0]            grant_idx;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t me;
  bit   mdue;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_value(fu_value), .fu_rd(fu_rd), .fu_pd(fu_pd), .fu_rob_idx(fu_rob_idx),
    .fu_dest_we(fu_dest_we), .cdb_valid(cdb_valid), .cdb_value(cdb_value),
    .cdb_rd(cdb_rd), .cdb_pd(cdb_pd), .cdb_rob_idx(cdb_rob_idx),
    .cdb_dest_we(cdb_dest_we), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [31:0] v, input logic [4:0] rd,
                        input logic [5:0] pd, input logic [3:0] rob, input logic we);
    fu_value[i] = v; fu_rd[i] = rd; fu_pd[i] = pd; fu_rob_idx[i] = rob; fu_dest_we[i] = we;
  endtask

  // One cycle: drive after the edge, optionally refresh one unit's fields,
  // then at negedge check the grant and queue the broadcast for next cycle.
  task automatic step(input logic r, input logic [NF-1:0] vld, input int exp,
                      input int upd = -1, input logic [31:0] v = '0, input logic [4:0] rd = '0,
                      input logic [5:0] pd = '0, input logic [3:0] rob = '0, input logic we = 1'b1);
    logic [NF-1:0] eg;
    exp_t e;
    @(posedge clk); #1;
    rst = r;
    fu_valid = vld;
    if (upd >= 0) set_fu(upd, v, rd, pd, rob, we);
    @(negedge clk);
    eg = (exp >= 0) ? (NF'(1) << exp) : '0;
    chk("fu_ready", 64'(fu_ready), 64'(eg));
    if (exp >= 0) begin
      e.due = cyc + 1; e.v = fu_value[exp]; e.rd = fu_rd[exp]; e.pd = fu_pd[exp];
      e.rob = fu_rob_idx[exp]; e.we = fu_dest_we[exp]; e.gi = 2'(exp);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mdue = (sb.size() > 0) && (sb[0].due == cyc);
    chk("cdb_valid", 64'(cdb_valid), 64'(mdue));
    if (mdue) begin
      me = sb.pop_front();
      chk("cdb_value",   64'(cdb_value),   64'(me.v));
      chk("cdb_rd",      64'(cdb_rd),      64'(me.rd));
      chk("cdb_pd",      64'(cdb_pd),      64'(me.pd));
      chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(me.rob));
      chk("cdb_dest_we", 64'(cdb_dest_we), 64'(me.we));
      chk("grant_idx",   64'(grant_idx),   64'(me.gi));
    end
  end

  initial begin
    rst = 1'b1;
    fu_valid = '1;
    for (int i = 0; i < NF; i++)
      set_fu(i, 32'h1000_0000 + 32'(i), 5'(i + 1), 6'(i + 10), 4'(i + 4), 1'b1);

    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fu_ready", 64'(fu_ready), 64'h0);
      chk("rst_cdb_fields", {cdb_value, cdb_rd, cdb_pd, cdb_rob_idx, cdb_dest_we, grant_idx}, 64'h0);
    end

    // all four streaming: strict rotation starting at unit 0
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1111, k % 4);
    step(1'b0, 4'b0000, -1);

    // single requester, then idle: fields hold
    step(1'b0, 4'b0100, 2, 2, 32'hFFFF_FFFF, 5'd7, 6'd5, 4'd3, 1'b1);
    step(1'b0, 4'b0000, -1);
    step(1'b0, 4'b0000, -1);
    chk("hold_value", 64'(cdb_value), 64'hFFFF_FFFF);

    // wrap-around: ptr=3 -> grant 3, then 0, then 3 with fresh fields
    step(1'b0, 4'b1000, 3);
    step(1'b0, 4'b1001, 0, 3, 32'h3333_0003, 5'd9, 6'd33, 4'd13, 1'b1);
    step(1'b0, 4'b1001, 3);

    // unit 0 streams, unit 1 waits at most one cycle
    set_fu(1, 32'h1111_AAAA, 5'd17, 6'd41, 4'd11, 1'b1);
    step(1'b0, 4'b0011, 0, 0, 32'hA000_0000, 5'd2, 6'd20, 4'd0, 1'b1);
    step(1'b0, 4'b0011, 1, 0, 32'hA000_0001, 5'd2, 6'd21, 4'd1, 1'b1);
    step(1'b0, 4'b0001, 0, 0, 32'hA000_0002, 5'd2, 6'd22, 4'd2, 1'b1);

    // completion-only result still broadcasts
    step(1'b0, 4'b0001, 0, 0, 32'hDEAD_BEEF, 5'd3, 6'd0, 4'd9, 1'b0);

    // mid-stream reset with units 1 and 2 pending
    step(1'b0, 4'b0110, 1);
    step(1'b1, 4'b0110, -1);
    step(1'b0, 4'b0110, 1);
    chk("post_rst_value", 64'(cdb_value), 64'h0);
    step(1'b0, 4'b0100, 2);
    step(1'b0, 4'b0000, -1);
    step(1'b0, 4'b0000, -1);

    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that collects completed results from the execution units (ALU, multiplier, divider, branch) and drives a single registered common data bus (CDB) broadcast per cycle. It sits directly downstream of each functional unit's response port (`resp_valid`/`resp_ready`/`resp_*`). It feeds the physical register file write port, the reservation-station wakeup logic and the ROB completion marking. At most one result is broadcast per cycle, and each requester gets fair access.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_FU`, 4, number of requesting functional units; 2..8.

Ports:
- `clk`  in  1  clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `fu_valid`  in  NUM_FU  per-unit result valid (unit's `resp_valid`).
- `fu_ready`  out  NUM_FU  per-unit grant (drives unit's `resp_ready`), one-hot or zero.
- `fu_value`  in  NUM_FU×XLEN  per-unit result value.
- `fu_rd`  in  NUM_FU×(ARCH_REG_IDX+1)  architectural destination.
- `fu_pd`  in  NUM_FU×(PHYS_REG_IDX+1)  physical destination.
- `fu_rob_idx`  in  NUM_FU×$clog2(NUM_ROB_ENTRIES)  ROB slot.
- `fu_dest_we`  in  NUM_FU  destination write enable.
- `cdb_valid`  out  1  broadcast valid this cycle.
- `cdb_value`  out  XLEN  broadcast value.
- `cdb_rd`  out  ARCH_REG_IDX+1  broadcast arch reg.
- `cdb_pd`  out  PHYS_REG_IDX+1  broadcast phys reg.
- `cdb_rob_idx`  out  $clog2(NUM_ROB_ENTRIES)  broadcast ROB index.
- `cdb_dest_we`  out  1  broadcast write enable; consumers write the PRF only when `cdb_valid && cdb_dest_we && cdb_pd != 0`.
- `grant_idx`  out  $clog2(NUM_FU)  index of the unit whose result is on the CDB (debug/perf).

## Operation
- Priority pointer `ptr` (0..NUM_FU-1). Search order is `ptr`, `ptr+1`, … mod NUM_FU. The first `i` with `fu_valid[i]` wins.
- `fu_ready[i]` is combinational: `fu_ready[i] = (i == winner) && any_valid`. It never depends on `fu_ready` of another unit. No combinational path from `fu_value`/`fu_rd`/… to `fu_ready`.
- A transfer occurs when `fu_valid[i] && fu_ready[i]`. The winner's fields are captured into the output register at the clock edge.
- The CDB has no backpressure: the arbiter grants every cycle that any `fu_valid` is high.
- Pointer update on a transfer from unit `i` is `ptr <= (i+1) mod NUM_FU`, with wrap from NUM_FU-1 to 0. With no transfer, `ptr` holds.
- Output register: `cdb_valid <= any_valid`. Data fields load only on a transfer and hold their previous value otherwise. Consumers must ignore fields while `cdb_valid=0`.
- `fu_dest_we=0` results are still broadcast, because the ROB needs completion. `cdb_dest_we` passes through unchanged.
- Requesters must hold `fu_valid` and their fields stable until granted; the FU output buffers guarantee this. The arbiter does not check it.
- Reset (any cycle, including mid-stream): `ptr=0`, `cdb_valid=0`, all `cdb_*` data fields 0, `grant_idx=0`. During reset `fu_ready=0`. Requests pending at reset are not granted. The FUs are reset in the same cycle.

## Timing
- Latency: 1 cycle. A result granted in cycle N appears on `cdb_*` in cycle N+1, valid for exactly one cycle.
- Throughput: 1 result/cycle. A single unit asserting `fu_valid` continuously is granted every cycle.
- With all NUM_FU units continuously valid, each unit is granted exactly once every NUM_FU cycles. Maximum wait for a valid unit is NUM_FU-1 cycles.
- Simultaneous requests: the lowest index at or after `ptr` (mod NUM_FU) wins. The others see `fu_ready=0` and hold.
- First cycle after reset deasserts: `ptr=0`, so unit 0 has top priority.

## Structure
- Shared package `rv32i_types` gains `cdb_t` (packed struct: `valid`, `value[XLEN]`, `rd`, `pd`, `rob_idx`, `dest_we`). It also gains the constant `NUM_FU`, used by the consumers.
- `cdb_*` outputs are the flattened fields of a registered `cdb_t`.
- One sub-module: `rr_arbiter` (parameter `N`; inputs `clk`, `rst`, `req[N]`, `advance`; outputs `gnt[N]` one-hot, `gnt_idx`). It owns `ptr` and the search logic. `cdb_arbiter` instantiates it plus the output register and field mux.

## Test plan
- Reset: hold `rst` 2 cycles with all `fu_valid=1` -> `fu_ready=0`, `cdb_valid=0`, all `cdb_*`=0. In the first cycle after reset, unit 0 is granted.
- Single requester: unit 2 (divider) presents value 0xFFFF_FFFF, pd=5, rob=3 for one cycle -> `fu_ready[2]=1` same cycle. Next cycle `cdb_valid=1`, `cdb_value=0xFFFF_FFFF`, `cdb_pd=5`, `cdb_rob_idx=3`, `grant_idx=2`. The cycle after, `cdb_valid=0`.
- Contention with NUM_FU=4: all four valid continuously for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3. Each broadcast is one cycle after its grant.
- Wrap-around: grant unit 3, then only units 0 and 3 valid -> unit 0 is granted next, then unit 3.
- Hold/starvation: unit 1 valid while unit 0 streams back-to-back -> unit 1 granted within 1 cycle. Unit 1's fields are stable until the grant and appear unchanged on the CDB.
- `fu_dest_we=0` result (e.g. store address from ALU, pd=0) -> broadcast with `cdb_valid=1`, `cdb_dest_we=0`. Mid-stream reset with units 1 and 2 pending -> `cdb_valid=0` the next cycle and `ptr` returns to 0.
